// File: rtl/funrv32_pkg.sv
// Shared definitions for the RV32 load/store path: size/sign codes, LSU state
// encoding and request classification helpers.
package funrv32_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DATA = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic lsu_legal(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

    // Only meaningful for legal codes; illegal ones are filtered first.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load size code.
module lsu_load_align
    import funrv32_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_rdata[{i_addr, 3'b000} +: 8];
        half_sel = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   o_data = {24'd0, byte_sel};
            F3_HU:   o_data = {16'd0, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates a request, issues one memory
// strobe when the memory is ready, and reports completion with a done pulse.
module load_store_unit
    import funrv32_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_resp_we,
    output logic [4:0]  o_resp_rd,
    output logic [31:0] o_resp_data,
    output logic        o_exc_misaligned,
    output logic        o_exc_illegal,
    output logic        o_dm_ren,
    output logic        o_dm_wen,
    output logic [3:0]  o_dm_ben,
    output logic [13:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata,
    input  logic        i_mem_ready
);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        done_q, done_d;
    logic        exc_mis_q, exc_mis_d;
    logic        exc_ill_q, exc_ill_d;
    logic        resp_we_q, resp_we_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] load_data;

    // Upper address bits alias onto the 64 KiB data memory.
    logic addr_hi_unused;
    assign addr_hi_unused = ^i_addr[31:16];

    lsu_load_align u_load_align (
        .i_rdata  (i_dm_rdata),
        .i_addr   (addr_q[1:0]),
        .i_funct3 (funct3_q),
        .o_data   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        exc_mis_d   = 1'b0;
        exc_ill_d   = 1'b0;
        resp_we_d   = 1'b0;
        resp_rd_d   = resp_rd_q;
        resp_data_d = resp_data_q;
        o_dm_ren    = 1'b0;
        o_dm_wen    = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (i_valid) begin
                    store_d  = i_store;
                    funct3_d = i_funct3;
                    addr_d   = i_addr[15:0];
                    wdata_d  = i_wdata;
                    rd_d     = i_rd;
                    if (!lsu_legal(i_store, i_funct3)) begin
                        done_d    = 1'b1;
                        exc_ill_d = 1'b1;
                    end else if (lsu_misaligned(i_funct3, i_addr[1:0])) begin
                        done_d    = 1'b1;
                        exc_mis_d = 1'b1;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (i_mem_ready) begin
                    if (store_q) begin
                        o_dm_wen = 1'b1;
                        done_d   = 1'b1;
                        state_d  = LSU_IDLE;
                    end else begin
                        o_dm_ren = 1'b1;
                        state_d  = LSU_DATA;
                    end
                end
            end
            LSU_DATA: begin
                resp_data_d = load_data;
                resp_rd_d   = rd_q;
                resp_we_d   = (rd_q != 5'd0);
                done_d      = 1'b1;
                state_d     = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Lane enables and replicated write data for the registered store.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                o_dm_ben   = 4'b0001 << addr_q[1:0];
                o_dm_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                o_dm_ben   = addr_q[1] ? 4'b1100 : 4'b0011;
                o_dm_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                o_dm_ben   = 4'b1111;
                o_dm_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= LSU_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            done_q      <= 1'b0;
            exc_mis_q   <= 1'b0;
            exc_ill_q   <= 1'b0;
            resp_we_q   <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            exc_mis_q   <= exc_mis_d;
            exc_ill_q   <= exc_ill_d;
            resp_we_q   <= resp_we_d;
            resp_rd_q   <= resp_rd_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign o_ready          = (state_q == LSU_IDLE);
    assign o_done           = done_q;
    assign o_exc_misaligned = exc_mis_q;
    assign o_exc_illegal    = exc_ill_q;
    assign o_resp_we        = resp_we_q;
    assign o_resp_rd        = resp_rd_q;
    assign o_resp_data      = resp_data_q;
    assign o_dm_addr        = addr_q[15:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a byte-level reference
// model that predicts every output cycle by cycle, plus literal spot checks.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_store, i_mem_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata, i_dm_rdata;
    logic [4:0]  i_rd;
    logic        o_ready, o_done, o_resp_we, o_exc_misaligned, o_exc_illegal;
    logic [4:0]  o_resp_rd;
    logic [31:0] o_resp_data, o_dm_wdata;
    logic        o_dm_ren, o_dm_wen;
    logic [3:0]  o_dm_ben;
    logic [13:0] o_dm_addr;

    load_store_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_store(i_store),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
        .o_ready(o_ready), .o_done(o_done), .o_resp_we(o_resp_we),
        .o_resp_rd(o_resp_rd), .o_resp_data(o_resp_data),
        .o_exc_misaligned(o_exc_misaligned), .o_exc_illegal(o_exc_illegal),
        .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben),
        .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
        .i_dm_rdata(i_dm_rdata), .i_mem_ready(i_mem_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory seen by the DUT, written only through its strobes (and preload).
    logic [31:0] dmem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_idx;
    logic [31:0] pl_val;

    always @(posedge i_clk) begin
        if (pl_en) dmem[pl_idx] <= pl_val;
        if (o_dm_ren) i_dm_rdata <= dmem[o_dm_addr];
        if (o_dm_wen)
            for (int b = 0; b < 4; b++)
                if (o_dm_ben[b]) dmem[o_dm_addr][8*b +: 8] <= o_dm_wdata[8*b +: 8];
    end

    // Reference byte memory, updated by the model at the architectural level.
    logic [7:0] ref_mem [0:65535];

    function automatic int size_of(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_legal(input logic st, input logic [2:0] f);
        if (st) return (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic logic m_misal(input logic [2:0] f, input logic [15:0] a);
        return ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) || (f == 3'd2 && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [15:0] a);
        logic [31:0] v;
        int n;
        n = size_of(f);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (f == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [3:0] m_ben(input logic [2:0] f, input logic [15:0] a);
        logic [3:0] m;
        m = 0;
        for (int k = 0; k < size_of(f); k++) m[(int'(a) + k) % 4] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = d[8*(l % size_of(f)) +: 8];
        return w;
    endfunction

    // Model state: at most one outstanding request, and the completion due next cycle.
    bit          armed = 0, m_busy = 0, m_issued = 0;
    logic        m_store;
    logic [2:0]  m_f3;
    logic [15:0] m_addr;
    logic [31:0] m_wd;
    logic [4:0]  m_rd;
    bit          d_now = 0, d_we = 0, d_mis = 0, d_ill = 0;
    logic [4:0]  d_rd;
    logic [31:0] m_resp = 0;

    always @(negedge i_clk) begin : model
        bit e_ren, e_wen;
        if (armed) begin
            e_ren = m_busy && !m_issued && !m_store && i_mem_ready;
            e_wen = m_busy && !m_issued && m_store && i_mem_ready;
            chk("ready", 32'(o_ready), 32'(!m_busy));
            chk("done", 32'(o_done), 32'(d_now));
            chk("ren", 32'(o_dm_ren), 32'(e_ren));
            chk("wen", 32'(o_dm_wen), 32'(e_wen));
            chk("resp_data", o_resp_data, m_resp);
            if (d_now) begin
                chk("resp_we", 32'(o_resp_we), 32'(d_we));
                chk("exc_mis", 32'(o_exc_misaligned), 32'(d_mis));
                chk("exc_ill", 32'(o_exc_illegal), 32'(d_ill));
                if (d_we) chk("resp_rd", 32'(o_resp_rd), 32'(d_rd));
            end
            if (e_ren || e_wen) chk("dm_addr", 32'(o_dm_addr), 32'(m_addr >> 2));
            if (e_wen) begin
                chk("dm_ben", 32'(o_dm_ben), 32'(m_ben(m_f3, m_addr)));
                chk("dm_wdata", o_dm_wdata, m_wdata(m_f3, m_wd));
            end
        end
        if (i_rst) begin
            armed = 1; m_busy = 0; m_issued = 0; d_now = 0; m_resp = 0;
        end else if (armed) begin
            d_now = 0; d_we = 0; d_mis = 0; d_ill = 0;
            if (m_busy && m_issued) begin
                m_resp = m_load(m_f3, m_addr);
                d_now = 1; d_we = (m_rd != 0); d_rd = m_rd;
                m_busy = 0; m_issued = 0;
            end else if (m_busy && i_mem_ready) begin
                if (m_store) begin
                    for (int k = 0; k < size_of(m_f3); k++)
                        ref_mem[int'(m_addr) + k] = m_wd[8*k +: 8];
                    d_now = 1; m_busy = 0;
                end else begin
                    m_issued = 1;
                end
            end else if (!m_busy && i_valid) begin
                if (!m_legal(i_store, i_funct3)) begin
                    d_now = 1; d_ill = 1;
                end else if (m_misal(i_funct3, i_addr[15:0])) begin
                    d_now = 1; d_mis = 1;
                end else begin
                    m_busy = 1; m_issued = 0; m_store = i_store; m_f3 = i_funct3;
                    m_addr = i_addr[15:0]; m_wd = i_wdata; m_rd = i_rd;
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic preload(input int unsigned widx, input logic [31:0] v);
        pl_en = 1'b1; pl_idx = widx[13:0]; pl_val = v;
        for (int b = 0; b < 4; b++) ref_mem[widx*4 + b] = v[8*b +: 8];
        step();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        bit acc;
        acc = 0;
        i_valid = 1'b1; i_store = st; i_funct3 = f; i_addr = a; i_wdata = d; i_rd = r;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge i_clk);
            acc = (o_ready === 1'b1);
            step();
        end
        i_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept: o_ready never 1 within 20 cycles, expected acceptance");
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            seen = (o_done === 1'b1);
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: o_done not seen within 20 cycles, expected a pulse", nm);
        end
    endtask

    typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] exp; } ld_vec_t;
    ld_vec_t lv [10] = '{
        '{3'd0, 32'h0000_0800, 32'h0000_0001},
        '{3'd0, 32'h0000_0801, 32'hFFFF_FF80},
        '{3'd4, 32'h0000_0801, 32'h0000_0080},
        '{3'd1, 32'h0000_0800, 32'hFFFF_8001},
        '{3'd5, 32'h0000_0800, 32'h0000_8001},
        '{3'd1, 32'h0000_0802, 32'hFFFF_F00D},
        '{3'd5, 32'h0000_0802, 32'h0000_F00D},
        '{3'd2, 32'h0000_0800, 32'hF00D_8001},
        '{3'd0, 32'h0000_0803, 32'hFFFF_FFF0},
        '{3'd2, 32'h0001_0800, 32'hF00D_8001}
    };

    typedef struct { logic st; logic [2:0] f3; logic [31:0] a; logic mis; logic ill; } ex_vec_t;
    ex_vec_t ev [11] = '{
        '{1'b0, 3'd3, 32'h800, 1'b0, 1'b1},
        '{1'b1, 3'd4, 32'h800, 1'b0, 1'b1},
        '{1'b0, 3'd6, 32'h000, 1'b0, 1'b1},
        '{1'b0, 3'd7, 32'h000, 1'b0, 1'b1},
        '{1'b1, 3'd3, 32'h000, 1'b0, 1'b1},
        '{1'b1, 3'd5, 32'h001, 1'b0, 1'b1},
        '{1'b0, 3'd1, 32'h001, 1'b1, 1'b0},
        '{1'b0, 3'd5, 32'h003, 1'b1, 1'b0},
        '{1'b0, 3'd2, 32'h002, 1'b1, 1'b0},
        '{1'b1, 3'd2, 32'h003, 1'b1, 1'b0},
        '{1'b1, 3'd1, 32'h005, 1'b1, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_funct3 = '0; i_addr = '0;
        i_wdata = '0; i_rd = '0; i_mem_ready = 1'b1;
        step();
        preload(32'h040, 32'h80FF_0000);
        preload(32'h200, 32'hF00D_8001);
        preload(32'h240, 32'h0000_0000);
        preload(32'h241, 32'h0000_0000);
        preload(32'h243, 32'h0000_0000);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_we", 32'(o_resp_we), 32'd0);
        chk("rst_rd", 32'(o_resp_rd), 32'd0);
        chk("rst_data", o_resp_data, 32'd0);
        chk("rst_exc", {30'd0, o_exc_misaligned, o_exc_illegal}, 32'd0);
        step();

        // SW cycle-exact
        issue(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 5'd0);
        @(negedge i_clk);
        chk("sw_wen", 32'(o_dm_wen), 32'd1);
        chk("sw_ben", 32'(o_dm_ben), 32'hF);
        chk("sw_addr", 32'(o_dm_addr), 32'h041);
        chk("sw_wdata", o_dm_wdata, 32'hDEAD_BEEF);
        @(negedge i_clk);
        chk("sw_done", 32'(o_done), 32'd1);
        chk("sw_we", 32'(o_resp_we), 32'd0);
        step();

        // LB / LBU at 0x103
        for (int u = 0; u < 2; u++) begin
            issue(1'b0, (u == 0) ? 3'd0 : 3'd4, 32'h103, 32'd0, 5'd5);
            @(negedge i_clk);
            chk("lb_ren", 32'(o_dm_ren), 32'd1);
            chk("lb_addr", 32'(o_dm_addr), 32'h040);
            @(negedge i_clk);
            chk("lb_nodone", 32'(o_done), 32'd0);
            @(negedge i_clk);
            chk("lb_done", 32'(o_done), 32'd1);
            chk("lb_data", o_resp_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_rd", 32'(o_resp_rd), 32'd5);
            chk("lb_we", 32'(o_resp_we), 32'd1);
            step();
        end

        // SH lanes, then misaligned LH
        issue(1'b1, 3'd1, 32'h2, 32'h1234_ABCD, 5'd0);
        @(negedge i_clk);
        chk("sh_ben", 32'(o_dm_ben), 32'hC);
        chk("sh_wdata", o_dm_wdata, 32'hABCD_ABCD);
        step();
        issue(1'b0, 3'd1, 32'h1, 32'd0, 5'd4);
        @(negedge i_clk);
        chk("lh_mis_done", 32'(o_done), 32'd1);
        chk("lh_mis_flag", 32'(o_exc_misaligned), 32'd1);
        chk("lh_mis_ren", 32'(o_dm_ren), 32'd0);
        step();

        // LW with memory stalled for three REQ cycles
        i_mem_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h800, 32'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("stall_ren", 32'(o_dm_ren), 32'd0);
            chk("stall_addr", 32'(o_dm_addr), 32'h200);
            step();
        end
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        chk("stall_ren4", 32'(o_dm_ren), 32'd1);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("stall_done", 32'(o_done), 32'd1);
        chk("stall_data", o_resp_data, 32'hF00D_8001);
        step();

        // LW rd=0 suppresses write-back
        issue(1'b0, 3'd2, 32'h800, 32'd0, 5'd0);
        wait_done("lw_rd0");
        chk("lw_rd0_we", 32'(o_resp_we), 32'd0);
        step();

        foreach (lv[i]) begin
            issue(1'b0, lv[i].f3, lv[i].a, 32'd0, 5'd7);
            wait_done("load_vec");
            chk("load_vec", o_resp_data, lv[i].exp);
            step();
        end

        foreach (ev[i]) begin
            issue(ev[i].st, ev[i].f3, ev[i].a, 32'h5A5A_5A5A, 5'd3);
            @(negedge i_clk);
            chk("exc_done", 32'(o_done), 32'd1);
            chk("exc_flags", {30'd0, o_exc_misaligned, o_exc_illegal}, {30'd0, ev[i].mis, ev[i].ill});
            step();
        end

        // Sub-word stores then readback
        issue(1'b1, 3'd0, 32'h901, 32'h0000_00AB, 5'd0);
        wait_done("sb");
        step();
        issue(1'b1, 3'd1, 32'h902, 32'h0000_5566, 5'd0);
        wait_done("sh");
        step();
        issue(1'b0, 3'd2, 32'h900, 32'd0, 5'd8);
        wait_done("rb1");
        chk("readback_sb_sh", o_resp_data, 32'h5566_AB00);
        step();

        // Back-to-back: second request held until the first one's done cycle
        issue(1'b1, 3'd0, 32'h904, 32'h11, 5'd0);
        issue(1'b1, 3'd0, 32'h905, 32'h22, 5'd0);
        wait_done("b2b");
        step();
        issue(1'b0, 3'd2, 32'h904, 32'd0, 5'd6);
        wait_done("rb2");
        chk("readback_b2b", o_resp_data, 32'h0000_2211);
        step();

        // Reset in DATA, with a request presented during reset
        issue(1'b0, 3'd2, 32'h800, 32'd0, 5'd3);
        step();
        i_rst = 1'b1;
        i_valid = 1'b1; i_store = 1'b1; i_funct3 = 3'd2; i_addr = 32'h908; i_wdata = 32'h7777_7777;
        step();
        i_rst = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("rstdata_ready", 32'(o_ready), 32'd1);
        chk("rstdata_done", 32'(o_done), 32'd0);
        chk("rstdata_strobe", {30'd0, o_dm_ren, o_dm_wen}, 32'd0);
        step();
        issue(1'b1, 3'd2, 32'h90C, 32'hCAFE_F00D, 5'd0);
        wait_done("sw_after_rst");
        chk("sw_after_rst_we", 32'(o_resp_we), 32'd0);
        step();
        issue(1'b0, 3'd2, 32'h90C, 32'd0, 5'd2);
        wait_done("rb3");
        chk("readback_after_rst", o_resp_data, 32'hCAFE_F00D);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
